ifetch_queue: RTL



---
 rtl/pipeline_pkg.sv | 17 +
 rtl/ifetch_queue_if.sv | 26 ++
 rtl/ifetch_fifo.sv | 57 +++++
 rtl/ifetch_queue.sv | 91 +++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared fetch/decode pipeline types and constants
package pipeline_pkg;

    localparam int PC_W    = 7;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_next;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - fetch stage bus: control, instruction memory, decode handshake
interface ifetch_queue_if;
    import pipeline_pkg::*;

    logic               enable;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc_next;

    modport master (
        input  enable, br_taken, br_target, imem_rdata, id_ready,
        output imem_req, imem_addr, id_valid, id_instr, id_pc_next
    );

    modport slave (
        output enable, br_taken, br_target, imem_rdata, id_ready,
        input  imem_req, imem_addr, id_valid, id_instr, id_pc_next
    );

endinterface

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous prefetch FIFO with flush and occupancy count
module ifetch_fifo
    import pipeline_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         valid,
    output logic [AW:0]  count
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush shares the reset path: it outranks any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(push && !do_pop && count == (AW+1)'(DEPTH)));
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch stage: PC, credit-based imem requests, prefetch queue (IFETCH_PERF_CNT_EN adds counters)
module ifetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    ifetch_queue_if.master bus
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] inflight_addr;
    logic [PC_W-1:0] issue_addr;
    logic            inflight;
    logic            issue;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [AW:0]     fifo_count;
    logic [AW+1:0]   credit_used;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    // Every outstanding request owns a queue slot, so a landing response never overflows.
    assign credit_used = {1'b0, fifo_count} + {{(AW+1){1'b0}}, inflight};
    assign issue       = rst && (bus.br_taken || (bus.enable && credit_used < (AW+2)'(DEPTH)));
    assign issue_addr  = (rst && bus.br_taken) ? bus.br_target : pc;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = issue_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc            <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc            <= pc_inc(issue_addr);
                inflight_addr <= issue_addr;
            end
        end
    end

    // A redirect kills the response landing this cycle; the target request is the new in-flight one.
    assign push      = inflight && !bus.br_taken;
    assign pop       = head_valid && bus.id_ready;
    assign push_data = '{instr: bus.imem_rdata, pc_next: pc_inc(inflight_addr)};

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.br_taken),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (head_valid),
        .count     (fifo_count)
    );

    assign bus.id_valid   = head_valid;
    assign bus.id_instr   = head_valid ? head.instr : NOP;
    assign bus.id_pc_next = head_valid ? head.pc_next : '0;

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (head_valid && !bus.id_ready && perf_stall_cnt != '1) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (bus.br_taken && perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
